logic_unit_pipe: RTL and testbench



---
 rtl/logic_pkg.sv | 19 +
 rtl/logic_op_comb.sv | 32 +++
 rtl/logic_unit_pipe.sv | 120 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic blocks.
// Holds the 3-bit operation encoding used by logic_op_comb and logic_unit_pipe,
// and by later ALU blocks that reuse the same op field.
package logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NAND  = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_comb.sv
// Combinational bitwise logic operator.
// Ports:
//   a, b : WIDTH-bit operands
//   op   : operation select (logic_pkg::op_e encoding)
//   y    : WIDTH-bit result
module logic_op_comb
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes.
// Stage 1 captures operands and op; stage 2 holds the result and its
// registered status flags. One transaction per cycle with full backpressure.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid, in_ready    : input handshake
//   a, b, op              : operands and operation select
//   out_valid, out_ready  : output handshake
//   y                     : result
//   y_zero, y_ones        : result is all zeros / all ones
//   y_parity              : XOR-reduction of the result
//   done_count            : completed output transfers, wrapping
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones,
  output logic             y_parity,
  output logic [CNT_W-1:0] done_count
);

  function automatic logic flag_zero(input logic [WIDTH-1:0] v);
    return ~|v;
  endfunction

  function automatic logic flag_ones(input logic [WIDTH-1:0] v);
    return &v;
  endfunction

  function automatic logic flag_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [OP_W-1:0]  op_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] y_comb;
  logic             take_p1;
  logic             take_p2;
  logic             in_xfer;
  logic             out_xfer;

  // A stage may advance when it is empty or its successor advances.
  assign take_p2   = !vld_p2 || out_ready;
  assign take_p1   = !vld_p1 || take_p2;
  assign in_ready  = take_p1;
  assign in_xfer   = in_valid && take_p1;
  assign out_valid = vld_p2;
  assign out_xfer  = vld_p2 && out_ready;

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (take_p1) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      a_p1  <= a;
      b_p1  <= b;
      op_p1 <= op;
    end
  end

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .a  (a_p1),
    .b  (b_p1),
    .op (op_p1),
    .y  (y_comb)
  );

  // ---- Stage 2: result and flags ----
  // Result registers load only with a real transaction so that y stays at the
  // last delivered value (or the reset value) while the pipe is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      y        <= '0;
      y_zero   <= 1'b1;
      y_ones   <= 1'b0;
      y_parity <= 1'b0;
    end else if (take_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        y        <= y_comb;
        y_zero   <= flag_zero(y_comb);
        y_ones   <= flag_ones(y_comb);
        y_parity <= flag_parity(y_comb);
      end
    end
  end

  // ---- Output transfer counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      done_count <= '0;
    end else if (out_xfer) begin
      done_count <= done_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
// A transaction-level model (queue of expected results, transfer counter)
// is compared against every output transfer.
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_ones;
  logic             y_parity;
  logic [CNT_W-1:0] done_count;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .y_zero     (y_zero),
    .y_ones     (y_ones),
    .y_parity   (y_parity),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference: result of one transaction from the op table.
  function automatic logic [WIDTH-1:0] model_op(input logic [WIDTH-1:0] ma,
                                                input logic [WIDTH-1:0] mb,
                                                input logic [2:0] mop);
    case (mop)
      3'd0: return ma & mb;
      3'd1: return ma | mb;
      3'd2: return ~(ma & mb);
      3'd3: return ~(ma | mb);
      3'd4: return ma ^ mb;
      3'd5: return ~(ma ^ mb);
      3'd6: return ~ma;
      default: return mb;
    endcase
  endfunction

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] out_log[$];
  int               model_count = 0;
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] prev_y;
  logic             bp_rand = 1'b0;

  // Transaction monitor and scoreboard, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_count = 0;
      hold_prev   = 1'b0;
    end else begin
      logic [WIDTH-1:0] e;
      chk("done_count", done_count, model_count % (1 << CNT_W));
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_y", y, prev_y);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("y", y, e);
          chk("y_zero", y_zero, (e == '0));
          chk("y_ones", y_ones, (e == '1));
          chk("y_parity", y_parity, ^e);
          out_log.push_back(y);
        end
        model_count++;
      end
      if (in_valid && in_ready)
        exp_q.push_back(model_op(a, b, op));
      hold_prev = out_valid && !out_ready;
      prev_y    = y;
    end
  end

  // Random backpressure when enabled.
  always begin
    @(posedge clk);
    #1;
    if (bp_rand) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic drive(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic [2:0] iop);
    logic acc;
    int   n;
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", acc, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_latency(input string tag);
    int n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, 2);
  endtask

  logic [WIDTH-1:0] seq_exp[8] = '{8'h42, 8'hDB, 8'hBD, 8'h24, 8'h99, 8'h66, 8'h3C, 8'h5A};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_done_count", done_count, 0);
    chk("rst_y_zero", y_zero, 1);
    chk("rst_y", y, 0);
    chk("rst_y_ones", y_ones, 0);
    chk("rst_parity", y_parity, 0);
    @(posedge clk);
    #1;

    // All eight ops back to back
    out_log.delete();
    drive(8'hC3, 8'h5A, 3'd0);
    in_valid = 1'b0;
    check_latency("latency_first");
    for (int i = 1; i < 8; i++) drive(8'hC3, 8'h5A, 3'(i));
    drain();
    chk("seq_len", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++)
      chk($sformatf("seq_y%0d", i), out_log[i], seq_exp[i]);
    chk("seq_done_count", done_count, 8);

    // Back-to-back stream without gaps
    out_log.delete();
    for (int i = 0; i < 8; i++) drive(8'hC3, 8'h5A, 3'(i));
    drain();
    for (int i = 0; i < 8 && i < out_log.size(); i++)
      chk($sformatf("stream_y%0d", i), out_log[i], seq_exp[i]);

    // NOR corner cases
    out_log.delete();
    drive(8'h00, 8'h00, 3'd3);
    drive(8'hFF, 8'h00, 3'd3);
    drain();
    chk("nor_len", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("nor_ff", out_log[0], 8'hFF);
      chk("nor_00", out_log[1], 8'h00);
    end

    // Backpressure: two accepted, third stalled
    out_ready = 1'b0;
    drive(8'h11, 8'hF0, 3'd1);
    drive(8'h22, 8'h0F, 3'd4);
    a = 8'h33; b = 8'h55; op = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_y_first", y, 8'hF1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_out0", out_valid, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_out%0d", i), out_valid, 1);
      @(posedge clk);
      #1;
    end
    drain();

    // Counter wrap after 17 transfers
    pulse_reset();
    for (int i = 0; i < 17; i++) drive(8'($urandom), 8'($urandom), 3'($urandom));
    drain();
    chk("wrap_count", done_count, 1);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(8'hAA, 8'h55, 3'd4);
    drive(8'h0F, 8'hF0, 3'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", done_count, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(8'h3C, 8'h0F, 3'd2);
    in_valid = 1'b0;
    check_latency("latency_after_rst");
    drain();
    chk("post_rst_count", done_count, 1);

    // Randomised traffic with random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(8'($urandom), 8'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    bp_rand = 1'b0;
    #1;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
